ov7670_capture: RTL
===================

Name: ov7670_capture

Overview:
Camera-side writer for the frame buffer that the VGA display path reads. Samples OV7670 parallel video (VSYNC/HREF/D[7:0]) in RGB444 two-bytes-per-pixel mode. Assembles 12-bit pixels and emits sequential write strobes with linear addresses into a dual-port frame-buffer BRAM. Addressing is row-major y*FRAME_W+x, the layout the display reader indexes.

Parameters:
FRAME_W, 320, active pixels per line stored; extra pixels dropped
FRAME_H, 240, active lines per frame stored; extra lines dropped
ADDR_W, 17, frame-buffer address width; must satisfy 2**ADDR_W >= FRAME_W*FRAME_H

Ports:
pixel_clk  input  1  camera PCLK; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cam_vsync  input  1  camera VSYNC, high = vertical blanking
cam_href  input  1  camera HREF, high = active line bytes valid
cam_data  input  8  camera pixel byte
capture_en  input  1  arm capture; sampled only at frame start
err_clear  input  1  clears err_sticky; has priority over same-cycle set
wr_en  output  1  one-cycle frame-buffer write strobe
wr_addr  output  ADDR_W  write address, y*FRAME_W+x
wr_data  output  12  pixel {R[3:0],G[3:0],B[3:0]}
frame_active  output  1  high while a frame is being captured
frame_done  output  1  one-cycle pulse after last stored line of a frame
err_sticky  output  2  [0]=odd byte count at HREF fall; [1]=line/frame overrun

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_active=0, frame_done=0, err_sticky=0. FSM=WAIT_VS_HIGH. Byte phase=0. x=y=0.
- Input stage: cam_vsync/cam_href/cam_data registered once; the FSM acts on the registered copies. vsync_fall and href_rise/href_fall are derived from the registered copy and a second delayed copy.
- FSM states and transitions:
  - WAIT_VS_HIGH: goes to WAIT_VS_LOW once vsync is seen high. This guarantees capture starts at a true frame boundary after reset.
  - WAIT_VS_LOW: on vsync_fall, if capture_en=1, go to FRAME: frame_active=1, x=y=0, wr_addr=0. If capture_en=0, return to WAIT_VS_HIGH.
  - FRAME: while href=1, bytes alternate phase 0 (high byte, low nibble = R) and phase 1 (low byte: G=[7:4], B=[3:0]).
  - FRAME, on phase-1 byte with x<FRAME_W and y<FRAME_H: wr_en=1 for one cycle, wr_data={R,G,B}, wr_addr=current linear address. The address increments after each write.
  - FRAME, latency: wr_en rises 2 pixel_clk edges after the edge on which the low byte is present at cam_data.
  - FRAME, on href_fall: phase reset to 0; if phase was 1, set err_sticky[0] and discard the half pixel.
  - FRAME, on href_fall, if y<FRAME_H: y+=1. If x<FRAME_W, pad wr_addr to the start of the next row (y*FRAME_W) so rows never shear. x=0.
  - FRAME, pixel overrun: pixels with x>=FRAME_W are dropped and set err_sticky[1] once per line.
  - FRAME, line overrun: lines with y>=FRAME_H are dropped and set err_sticky[1].
  - FRAME, on vsync rising: frame_done pulses one cycle, frame_active=0, go to WAIT_VS_LOW. capture_en deassertion mid-frame does not abort the frame.
- VSYNC rising while href=1 (mid-line): abort the line, no further writes, then treat as frame end.
- Address arithmetic uses a running counter plus a row-base register. No multiplier. Never exceeds FRAME_W*FRAME_H-1.
- Reset asserted mid-frame: all state cleared immediately. Capture resumes only after a full vsync high->low cycle.

Optional Feature:
CAPTURE_STATS_EN
- Defined: adds outputs frame_count[15:0] (wrapping count of frame_done pulses), last_line_count[9:0] (HREF pulses in the previous frame, saturating at 1023) and last_pix_count[10:0] (pixels in the last line, saturating at 2047). All three reset to 0 and update on frame_done or href_fall.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Package ov7670_capture_pkg: FSM state enum (WAIT_VS_HIGH, WAIT_VS_LOW, FRAME), pixel width 12, byte-phase constants, err_sticky bit indices.
- Sub-module cam_sync_edge: input registers plus rise/fall detection for vsync/href, with a pass-through data byte.

Test Plan:
- Reset, then vsync 1->0 with capture_en=1, one 320-pixel line (bytes 0x0A,0xBC repeated) -> 320 writes, wr_data=0xABC, wr_addr 0..319, err_sticky=0.
- Full 240-line frame, then vsync high -> last wr_addr=76799, exactly one frame_done pulse, frame_active falls.
- Line of 330 pixels -> only 320 writes, err_sticky[1]=1. Next line starts at wr_addr=320. err_clear -> err_sticky=0.
- Line with 300 pixels, then HREF falls after an odd byte -> writes 0..299, err_sticky[0]=1, next line's first write at 320.
- capture_en=0 at vsync fall -> zero writes for the whole frame. Reset asserted mid-line -> outputs zero at once; no writes until a full vsync cycle completes.
- CAPTURE_STATS_EN defined, two frames of 240x320 -> frame_count=2, last_line_count=240, last_pix_count=320.

Source files
------------

// File: rtl/ov7670_capture_pkg.sv
// ov7670_capture_pkg: shared FSM states, pixel width, byte-phase and error-bit constants
package ov7670_capture_pkg;
  typedef enum logic [1:0] {WAIT_VS_HIGH, WAIT_VS_LOW, FRAME} state_t;
  localparam int PIX_W = 12;
  localparam logic PH_HI = 1'b0;
  localparam logic PH_LO = 1'b1;
  localparam int ERR_ODD = 0;
  localparam int ERR_OVR = 1;
endpackage

// File: rtl/ov7670_capture_if.sv
// ov7670_capture_if: frame-buffer write port (strobe, linear address, 12-bit pixel)
interface ov7670_capture_if #(parameter int ADDR_W = 17);
  import ov7670_capture_pkg::*;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  modport master(output wr_en, wr_addr, wr_data);
  modport slave(input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: registers camera vsync/href/data once and flags vsync/href edges
module cam_sync_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] data,
  output logic       vsync_r,
  output logic       href_r,
  output logic [7:0] data_r,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_fall
);
  logic vsync_d, href_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {vsync_r, href_r, data_r, vsync_d, href_d} <= '0;
    else {vsync_r, href_r, data_r, vsync_d, href_d} <= {vsync, href, data, vsync_r, href_r};
  end
  assign vsync_rise = vsync_r & ~vsync_d;
  assign vsync_fall = ~vsync_r & vsync_d;
  assign href_fall  = ~href_r & href_d;
endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture: OV7670 RGB444 capture into a row-major frame buffer at y*FRAME_W+x.
// Defining CAPTURE_STATS_EN adds frame_count/last_line_count/last_pix_count outputs.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int ADDR_W  = 17
) (
  input  logic                    pixel_clk,
  input  logic                    rst_n,
  input  logic                    cam_vsync,
  input  logic                    cam_href,
  input  logic [7:0]              cam_data,
  input  logic                    capture_en,
  input  logic                    err_clear,
  ov7670_capture_if.master        fb,
  output logic                    frame_active,
  output logic                    frame_done,
  output logic [1:0]              err_sticky
`ifdef CAPTURE_STATS_EN
  ,
  output logic [15:0]             frame_count,
  output logic [9:0]              last_line_count,
  output logic [10:0]             last_pix_count
`endif
);
  localparam int XW = $clog2(FRAME_W + 1);
  localparam int YW = $clog2(FRAME_H + 1);
  localparam logic [XW-1:0] W_X = XW'(FRAME_W);
  localparam logic [YW-1:0] H_Y = YW'(FRAME_H);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(FRAME_W);
  state_t state, state_n;
  logic vs, hr, vs_rise, vs_fall, hfall;
  logic [7:0] d;
  logic phase, phase_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [ADDR_W-1:0] addr, addr_n, row_base, row_n, wa, wa_n;
  logic [3:0] red, red_n;
  logic we, we_n, act_n, done_n;
  logic [PIX_W-1:0] wd, wd_n;
  logic [1:0] err_n;
  cam_sync_edge u_sync (
    .clk(pixel_clk),
    .rst_n(rst_n),
    .vsync(cam_vsync),
    .href(cam_href),
    .data(cam_data),
    .vsync_r(vs),
    .href_r(hr),
    .data_r(d),
    .vsync_rise(vs_rise),
    .vsync_fall(vs_fall),
    .href_fall(hfall)
  );
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_VS_HIGH;
      {phase, x, y, addr, row_base, red, we, wa, wd, frame_active, frame_done, err_sticky} <= '0;
    end else begin
      state <= state_n;
      {phase, x, y, addr, row_base, red, we, wa, wd, frame_active, frame_done, err_sticky} <=
        {phase_n, x_n, y_n, addr_n, row_n, red_n, we_n, wa_n, wd_n, act_n, done_n, err_n};
    end
  end
  // wr_addr only moves on a write, so it never shows the one-past-end running counter
  always_comb begin
    state_n = state;
    phase_n = phase;
    x_n = x;
    y_n = y;
    addr_n = addr;
    row_n = row_base;
    red_n = red;
    we_n = 1'b0;
    wa_n = wa;
    wd_n = wd;
    act_n = frame_active;
    done_n = 1'b0;
    err_n = err_sticky;
    unique case (state)
      WAIT_VS_HIGH: state_n = vs ? WAIT_VS_LOW : WAIT_VS_HIGH;
      WAIT_VS_LOW: if (vs_fall) begin
        state_n = capture_en ? FRAME : WAIT_VS_HIGH;
        if (capture_en) begin
          act_n = 1'b1;
          phase_n = PH_HI;
          x_n = '0;
          y_n = '0;
          addr_n = '0;
          row_n = '0;
          wa_n = '0;
        end
      end
      FRAME: if (vs_rise) begin
        state_n = WAIT_VS_LOW;
        act_n = 1'b0;
        done_n = 1'b1;
        phase_n = PH_HI;
      end else if (hr) begin
        phase_n = ~phase;
        if (phase == PH_HI) red_n = d[3:0];
        else if (x < W_X && y < H_Y) begin
          we_n = 1'b1;
          wa_n = addr;
          wd_n = {red, d};
          addr_n = addr + 1'b1;
          x_n = x + 1'b1;
        end else err_n[ERR_OVR] = 1'b1;
      end else if (hfall) begin
        phase_n = PH_HI;
        if (phase == PH_LO) err_n[ERR_ODD] = 1'b1;
        if (y < H_Y) begin
          y_n = y + 1'b1;
          row_n = row_base + W_A;
          addr_n = row_base + W_A;
        end
        x_n = '0;
      end
      default: state_n = WAIT_VS_HIGH;
    endcase
    if (err_clear) err_n = '0;
  end
  assign fb.wr_en = we;
  assign fb.wr_addr = wa;
  assign fb.wr_data = wd;
`ifdef CAPTURE_STATS_EN
  logic [9:0] line_cnt;
  logic [10:0] pix_cnt;
  logic in_frame;
  assign in_frame = state == FRAME && !vs_rise;
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) {frame_count, last_line_count, last_pix_count, line_cnt, pix_cnt} <= '0;
    else if (state == FRAME && vs_rise) begin
      frame_count <= frame_count + 1'b1;
      last_line_count <= line_cnt;
    end else if (state == WAIT_VS_LOW && vs_fall && capture_en) {line_cnt, pix_cnt} <= '0;
    else if (in_frame && hfall) begin
      line_cnt <= line_cnt + {9'd0, line_cnt != '1};
      last_pix_count <= pix_cnt;
      pix_cnt <= '0;
    end else if (in_frame && hr && phase == PH_LO) pix_cnt <= pix_cnt + {10'd0, pix_cnt != '1};
  end
`endif
endmodule
